// File: rtl/data_bus_bridge_if.sv
// data_bus_bridge_if
// Purpose: single-beat memory bus between the load/store bridge and the
//          memory side. The request phase uses a valid/ready handshake. Read
//          data returns on bus_rvalid, either in the accept cycle or later.
// Signals:
//   bus_valid  bridge -> mem  request valid
//   bus_ready  mem -> bridge  request accepted this cycle
//   bus_we     bridge -> mem  1 = write
//   bus_be     bridge -> mem  byte enables
//   bus_addr   bridge -> mem  word-aligned address
//   bus_wdata  bridge -> mem  write data, replicated across lanes
//   bus_rdata  mem -> bridge  read data
//   bus_rvalid mem -> bridge  read data valid
interface data_bus_bridge_if;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;

   modport master (
      output bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
      input  bus_ready, bus_rdata, bus_rvalid
   );

   modport slave (
      input  bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
      output bus_ready, bus_rdata, bus_rvalid
   );
endinterface

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
// Purpose: converts core load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW)
//          into single bus transactions. It generates byte-lane enables and
//          replicated write data, formats the returned load data, and stalls
//          the core while an access is in flight. An illegal op, a misaligned
//          access or a bus timeout produces a one-cycle err pulse.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   req_valid   core presents a load/store
//   load_store  0 = load, 1 = store
//   load_ops    load width/sign code
//   store_ops   store width code
//   addr        byte address
//   data_in     store data
//   data_out    formatted load data
//   stall       core must hold PC and request
//   err         one-cycle error pulse
//   bus         memory-side bus (master modport)
//
// state | meaning
// IDLE  | waiting for a request; decode and launch or reject
// REQ   | bus_valid high, bus outputs frozen until bus_ready
// RESP  | request accepted, waiting for bus_rvalid on a load
// DONE  | access complete, stall released, data_out valid
// ERR   | err pulse, stall released, data_out cleared
module data_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        load_store,
   input  logic [2:0]  load_ops,
   input  logic [2:0]  store_ops,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        stall,
   output logic        err,
   data_bus_bridge_if.master bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;

   state_t         state;
   logic [CW-1:0]  tmo_cnt;
   logic [2:0]     op_q;
   logic [1:0]     lo_q;

   logic [2:0]     op_sel;
   logic [1:0]     size;
   logic           op_legal;
   logic           misaligned;
   logic [3:0]     be_req;
   logic [31:0]    wdata_req;
   logic           timeout_hit;
   logic [31:0]    load_fmt;

   assign op_sel = load_store ? store_ops : load_ops;
   assign size   = op_sel[1:0];

   always_comb begin
      op_legal = 1'b0;
      if (load_store) begin
         case (store_ops)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            default:                op_legal = 1'b0;
         endcase
      end else begin
         case (load_ops)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
         endcase
      end
   end

   assign misaligned = ((size == 2'b01) && addr[0]) ||
                       ((size == 2'b10) && (addr[1:0] != 2'b00));

   always_comb begin
      be_req    = 4'b1111;
      wdata_req = data_in;
      case (size)
         2'b00: begin
            be_req    = 4'b0001 << addr[1:0];
            wdata_req = {4{data_in[7:0]}};
         end
         2'b01: begin
            be_req    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_req = {2{data_in[15:0]}};
         end
         default: begin
            be_req    = 4'b1111;
            wdata_req = data_in;
         end
      endcase
   end

   // Byte/halfword lane select uses the captured address offset, not the live
   // core address, so the core may already be presenting its next request.
   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      case (lo_q)
         2'b00:   b = bus.bus_rdata[7:0];
         2'b01:   b = bus.bus_rdata[15:8];
         2'b10:   b = bus.bus_rdata[23:16];
         default: b = bus.bus_rdata[31:24];
      endcase
      h = lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (op_q)
         3'b000:  load_fmt = {{24{b[7]}}, b};
         3'b001:  load_fmt = {{16{h[15]}}, h};
         3'b100:  load_fmt = {24'h0, b};
         3'b101:  load_fmt = {16'h0, h};
         default: load_fmt = bus.bus_rdata;
      endcase
   end

   // Counter is one bit wider than needed so that an accept on the last REQ
   // cycle can carry into RESP without wrapping; RESP then times out on >=.
   assign timeout_hit = (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));

   assign stall = req_valid && !reset &&
                  ((state == IDLE) || (state == REQ) || (state == RESP));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         tmo_cnt       <= '0;
         op_q          <= '0;
         lo_q          <= '0;
         data_out      <= '0;
         err           <= 1'b0;
         bus.bus_valid <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_be    <= '0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (op_legal && !misaligned) begin
                     state         <= REQ;
                     tmo_cnt       <= '0;
                     op_q          <= op_sel;
                     lo_q          <= addr[1:0];
                     bus.bus_valid <= 1'b1;
                     bus.bus_we    <= load_store;
                     bus.bus_be    <= be_req;
                     bus.bus_addr  <= {addr[31:2], 2'b00};
                     bus.bus_wdata <= wdata_req;
                  end else begin
                     state    <= ERR;
                     err      <= 1'b1;
                     data_out <= '0;
                  end
               end
            end
            REQ: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // An accept in the last allowed cycle takes priority over the timeout.
               if (bus.bus_ready) begin
                  bus.bus_valid <= 1'b0;
                  if (bus.bus_we) begin
                     state <= DONE;
                  end else if (bus.bus_rvalid) begin
                     data_out <= load_fmt;
                     state    <= DONE;
                  end else begin
                     state <= RESP;
                  end
               end else if (timeout_hit) begin
                  bus.bus_valid <= 1'b0;
                  state         <= ERR;
                  err           <= 1'b1;
                  data_out      <= '0;
               end
            end
            RESP: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (bus.bus_rvalid) begin
                  data_out <= load_fmt;
                  state    <= DONE;
               end else if (timeout_hit) begin
                  state    <= ERR;
                  err      <= 1'b1;
                  data_out <= '0;
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        load_store;
   logic [2:0]  load_ops;
   logic [2:0]  store_ops;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        stall;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   data_bus_bridge_if bif ();

   data_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .load_store (load_store),
      .load_ops   (load_ops),
      .store_ops  (store_ops),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .stall      (stall),
      .err        (err),
      .bus        (bif.master)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (from the access rules) ----------------
   function automatic bit m_legal(input bit ls, input logic [2:0] op);
      if (ls) return (op == 3'd0) || (op == 3'd1) || (op == 3'd2);
      return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
   endfunction

   function automatic int m_bytes(input logic [2:0] op);
      return 1 << op[1:0];
   endfunction

   function automatic bit m_ok(input bit ls, input logic [2:0] op, input logic [31:0] a);
      if (!m_legal(ls, op)) return 1'b0;
      return (int'(a[1:0]) % m_bytes(op)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
      logic [3:0] be = '0;
      for (int i = 0; i < m_bytes(op); i++) be[int'(a[1:0]) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % m_bytes(op)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
      int n = m_bytes(op);
      logic [31:0] v, mask;
      v = rd >> (8 * int'(a[1:0]));
      if (n == 4) return v;
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!op[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- stimulus driver (observations only) ----------------
   task automatic drive_access(
      input  bit ls, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
      input  int rdy_wait, input int rv_wait, input logic [31:0] rdata,
      output int stalls, output int err_cycles, output bit valid_seen, output bit stable_ok,
      output logic [3:0] be, output logic we, output logic [31:0] baddr,
      output logic [31:0] wdata, output logic [31:0] dout, output bit valid_at_end,
      output bit done);
      int  vcyc = 0;
      int  k = 0;
      bit  accepted = 0;
      stalls = 0; err_cycles = 0; valid_seen = 0; stable_ok = 1;
      be = '0; we = 1'b0; baddr = '0; wdata = '0; dout = '0; valid_at_end = 0; done = 0;
      @(posedge clk); #1;
      req_valid  = 1'b1;
      load_store = ls;
      load_ops   = ls ? 3'($urandom) : op;
      store_ops  = ls ? op : 3'($urandom);
      addr       = a;
      data_in    = d;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (cyc > 0) begin @(posedge clk); #1; end
         bif.bus_ready  = 1'b0;
         bif.bus_rvalid = 1'b0;
         bif.bus_rdata  = $urandom;
         if (bif.bus_valid) begin
            if (!valid_seen) begin
               be = bif.bus_be; we = bif.bus_we; baddr = bif.bus_addr; wdata = bif.bus_wdata;
            end else if (be !== bif.bus_be || we !== bif.bus_we ||
                         baddr !== bif.bus_addr || wdata !== bif.bus_wdata) begin
               stable_ok = 0;
            end
            valid_seen = 1;
            if (vcyc >= rdy_wait) begin
               bif.bus_ready = 1'b1;
               accepted = 1;
               k = 0;
               if (!ls && rv_wait == 0) begin
                  bif.bus_rvalid = 1'b1;
                  bif.bus_rdata  = rdata;
               end
            end
            vcyc++;
         end else if (accepted && !ls) begin
            k++;
            if (k == rv_wait) begin
               bif.bus_rvalid = 1'b1;
               bif.bus_rdata  = rdata;
            end
         end
         #1;
         if (err === 1'b1) err_cycles++;
         if (stall === 1'b1) stalls++;
         else if (cyc > 0) begin
            done = 1;
            dout = data_out;
            valid_at_end = bif.bus_valid;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0; bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0;
      #1;
      if (err === 1'b1) err_cycles++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      @(posedge clk); #1;
      reset = 1'b1; req_valid = 1'b1; load_store = 1'b1; store_ops = 3'd2;
      addr = 32'h100; data_in = 32'h5555_AAAA;
      bif.bus_ready = 1'b1; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bif.bus_valid, bif.bus_we, bif.bus_be} !== 6'b0) begin
         n_fail++; $display("FAIL reset_bus_ctl: got %b want 000000", {bif.bus_valid, bif.bus_we, bif.bus_be});
      end
      n_checks++;
      if (bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_bus_data: got addr %h wdata %h want 0", bif.bus_addr, bif.bus_wdata);
      end
      n_checks++;
      if (data_out !== 32'h0 || err !== 1'b0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL reset_core: got dout %h err %b stall %b want 0/0/0", data_out, err, stall);
      end
      req_valid = 1'b0; bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      // stray read data in IDLE must be ignored
      @(posedge clk); #1;
      bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      bif.bus_rvalid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (data_out !== 32'h0 || bif.bus_valid !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL idle_rvalid_ignored: got dout %h valid %b err %b want 0/0/0", data_out, bif.bus_valid, err);
      end
   endtask

   task automatic test_scenarios;
      int st, ec; bit vs, so, ve, dn; logic [3:0] be; logic we; logic [31:0] ba, wd, dout;
      // SW zero-wait
      drive_access(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if ({we, be} !== 5'b1_1111 || ba !== 32'h100 || wd !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL sw_bus: got we %b be %b addr %h wdata %h want 1 1111 100 deadbeef", we, be, ba, wd);
      end
      n_checks++;
      if (st !== 2 || ec !== 0 || !dn) begin
         n_fail++; $display("FAIL sw_stall: got stalls %0d err %0d done %0d want 2 0 1", st, ec, dn);
      end
      // LB / LBU at 0x103, rvalid two cycles after accept
      drive_access(0, 3'd0, 32'h103, 0, 0, 2, 32'h80FF_0000, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (be !== 4'b1000 || dout !== 32'hFFFF_FF80 || ba !== 32'h100) begin
         n_fail++; $display("FAIL lb: got be %b dout %h addr %h want 1000 ffffff80 100", be, dout, ba);
      end
      n_checks++;
      if (st !== 4 || ec !== 0) begin
         n_fail++; $display("FAIL lb_stall: got stalls %0d err %0d want 4 0", st, ec);
      end
      drive_access(0, 3'd4, 32'h103, 0, 0, 2, 32'h80FF_0000, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (dout !== 32'h0000_0080) begin
         n_fail++; $display("FAIL lbu: got %h want 00000080", dout);
      end
      drive_access(0, 3'd1, 32'h102, 0, 1, 2, 32'h80FF_0000, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (dout !== 32'hFFFF_80FF || be !== 4'b1100) begin
         n_fail++; $display("FAIL lh: got dout %h be %b want ffff80ff 1100", dout, be);
      end
      drive_access(1, 3'd1, 32'h102, 32'h0000_1234, 0, 0, 0, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (be !== 4'b1100 || wd !== 32'h1234_1234 || we !== 1'b1) begin
         n_fail++; $display("FAIL sh: got be %b wdata %h we %b want 1100 12341234 1", be, wd, we);
      end
   endtask

   task automatic test_errors;
      int st, ec; bit vs, so, ve, dn; logic [3:0] be; logic we; logic [31:0] ba, wd, dout;
      drive_access(0, 3'd2, 32'h101, 0, 0, 0, 32'hFFFF_FFFF, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (vs !== 1'b0 || ec !== 1 || st !== 1 || dout !== 32'h0) begin
         n_fail++; $display("FAIL lw_misaligned: got valid %b errcyc %0d stalls %0d dout %h want 0 1 1 0", vs, ec, st, dout);
      end
      drive_access(0, 3'd3, 32'h100, 0, 0, 0, 32'hFFFF_FFFF, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (vs !== 1'b0 || ec !== 1 || st !== 1) begin
         n_fail++; $display("FAIL illegal_load: got valid %b errcyc %0d stalls %0d want 0 1 1", vs, ec, st);
      end
   endtask

   task automatic test_timeout;
      int st, ec; bit vs, so, ve, dn; logic [3:0] be; logic we; logic [31:0] ba, wd, dout;
      drive_access(1, 3'd2, 32'h40, 32'hA5A5_5A5A, 1000, 0, 0, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (ec !== 1 || st !== 17 || ve !== 1'b0 || !dn || so !== 1'b1) begin
         n_fail++; $display("FAIL timeout: got errcyc %0d stalls %0d valid_end %b done %0d stable %0d want 1 17 0 1 1", ec, st, ve, dn, so);
      end
      drive_access(1, 3'd2, 32'h40, 32'hA5A5_5A5A, 15, 0, 0, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (ec !== 0 || st !== 17 || !dn) begin
         n_fail++; $display("FAIL timeout_edge_store: got errcyc %0d stalls %0d done %0d want 0 17 1", ec, st, dn);
      end
      drive_access(0, 3'd2, 32'h44, 0, 15, 0, 32'h0BAD_CAFE, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (ec !== 0 || dout !== 32'h0BAD_CAFE) begin
         n_fail++; $display("FAIL timeout_edge_load: got errcyc %0d dout %h want 0 0badcafe", ec, dout);
      end
   endtask

   task automatic test_req_drop;
      @(posedge clk); #1;
      req_valid = 1'b1; load_store = 1'b0; load_ops = 3'd2; addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bif.bus_valid !== 1'b1 || stall !== 1'b0) begin
         n_fail++; $display("FAIL req_drop_hold: got valid %b stall %b want 1 0", bif.bus_valid, stall);
      end
      bif.bus_ready = 1'b1;
      @(posedge clk); #1;
      bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h1122_3344;
      @(posedge clk); #1;
      bif.bus_rvalid = 1'b0;
      n_checks++;
      if (data_out !== 32'h1122_3344 || err !== 1'b0) begin
         n_fail++; $display("FAIL req_drop_complete: got dout %h err %b want 11223344 0", data_out, err);
      end
   endtask

   task automatic test_reset_mid_txn;
      int st, ec; bit vs, so, ve, dn; logic [3:0] be; logic we; logic [31:0] ba, wd, dout;
      drive_access(0, 3'd2, 32'h104, 0, 0, 1, 32'hCAFE_F00D, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      // load into RESP, then reset
      @(posedge clk); #1;
      req_valid = 1'b1; load_store = 1'b0; load_ops = 3'd2; addr = 32'h200;
      @(posedge clk); #1;
      bif.bus_ready = 1'b1;
      @(posedge clk); #1;
      bif.bus_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (data_out !== 32'hCAFE_F00D || stall !== 1'b1) begin
         n_fail++; $display("FAIL resp_before_reset: got dout %h stall %b want cafef00d 1", data_out, stall);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bif.bus_valid !== 1'b0 || data_out !== 32'h0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_resp: got valid %b dout %h stall %b want 0 0 0", bif.bus_valid, data_out, stall);
      end
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      bif.bus_rvalid = 1'b0;
      #1;
      n_checks++;
      if (data_out !== 32'h0 || err !== 1'b0 || bif.bus_valid !== 1'b0) begin
         n_fail++; $display("FAIL late_rvalid: got dout %h err %b valid %b want 0 0 0", data_out, err, bif.bus_valid);
      end
      // reset while in REQ drops bus_valid at once
      req_valid = 1'b1; load_store = 1'b1; store_ops = 3'd2; addr = 32'h300;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (bif.bus_valid !== 1'b1) begin
         n_fail++; $display("FAIL req_before_reset: got valid %b want 1", bif.bus_valid);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bif.bus_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_req: got valid %b want 0", bif.bus_valid);
      end
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0;
      drive_access(1, 3'd2, 32'h100, 32'h0F0F_1234, 0, 0, 0, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
      n_checks++;
      if (st !== 2 || ec !== 0 || be !== 4'b1111 || wd !== 32'h0F0F_1234 || ba !== 32'h100) begin
         n_fail++; $display("FAIL sw_after_reset: got stalls %0d err %0d be %b wdata %h addr %h", st, ec, be, wd, ba);
      end
   endtask

   task automatic test_random;
      int st, ec; bit vs, so, ve, dn; logic [3:0] be; logic we; logic [31:0] ba, wd, dout;
      bit ls; logic [2:0] op; logic [31:0] a, d, rd; int rw, vw, exp_st;
      logic [2:0] legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int it = 0; it < 60; it++) begin
         ls = 1'($urandom);
         if ($urandom_range(0, 3) == 0) op = 3'($urandom);
         else op = ls ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
         a  = $urandom; d = $urandom; rd = $urandom;
         rw = $urandom_range(0, 3); vw = $urandom_range(0, 3);
         drive_access(ls, op, a, d, rw, vw, rd, st, ec, vs, so, be, we, ba, wd, dout, ve, dn);
         if (m_ok(ls, op, a)) begin
            exp_st = 2 + rw + (ls ? 0 : vw);
            n_checks++;
            if (!dn || ec !== 0 || st !== exp_st || vs !== 1'b1 || so !== 1'b1) begin
               n_fail++; $display("FAIL rand_flow it%0d: got done %0d err %0d stalls %0d valid %0d stable %0d want 1 0 %0d 1 1", it, dn, ec, st, vs, so, exp_st);
            end
            n_checks++;
            if (be !== m_be(op, a) || we !== ls || ba !== {a[31:2], 2'b00}) begin
               n_fail++; $display("FAIL rand_bus it%0d: got be %b we %b addr %h want %b %b %h", it, be, we, ba, m_be(op, a), ls, {a[31:2], 2'b00});
            end
            if (ls) begin
               n_checks++;
               if (wd !== m_wdata(op, d)) begin
                  n_fail++; $display("FAIL rand_wdata it%0d: got %h want %h", it, wd, m_wdata(op, d));
               end
            end else begin
               n_checks++;
               if (dout !== m_load(op, a, rd)) begin
                  n_fail++; $display("FAIL rand_load it%0d op%0d: got %h want %h", it, op, dout, m_load(op, a, rd));
               end
            end
         end else begin
            n_checks++;
            if (!dn || ec !== 1 || st !== 1 || vs !== 1'b0 || dout !== 32'h0) begin
               n_fail++; $display("FAIL rand_err it%0d: got done %0d err %0d stalls %0d valid %0d dout %h want 1 1 1 0 0", it, dn, ec, st, vs, dout);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; load_store = 1'b0; load_ops = '0; store_ops = '0;
      addr = '0; data_in = '0;
      bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
      test_reset();
      test_scenarios();
      test_errors();
      test_timeout();
      test_req_drop();
      test_reset_mid_txn();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got running want finished");
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles a transaction may wait in REQ plus RESP before it is aborted.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, rising-edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  core is presenting a load or store this cycle.
REQ-006 load_store  in  1  0 = load, 1 = store.
REQ-007 load_ops  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are illegal.
REQ-008 store_ops  in  3  000 SB, 001 SH, 010 SW; other codes are illegal.
REQ-009 addr  in  32  byte address, equal to the ALU result.
REQ-010 data_in  in  32  store data, equal to rs2.
REQ-011 data_out  out  32  formatted load data returned to the writeback mux.
REQ-012 stall  out  1  high means the core holds its PC and request.
REQ-013 err  out  1  one-cycle pulse on a misaligned access, illegal op or timeout.
REQ-014 bus_valid  out  1  bus request valid.
REQ-015 bus_ready  in  1  bus accepts the request.
REQ-016 bus_we  out  1  1 = write.
REQ-017 bus_be  out  4  byte enables.
REQ-018 bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-019 bus_wdata  out  32  store data replicated into lanes.
REQ-020 bus_rdata  in  32  read data.
REQ-021 bus_rvalid  in  1  read data valid.

Function
REQ-022 The FSM SHALL have the states IDLE, REQ, RESP, DONE and ERR.
REQ-023 IDLE: on req_valid with a legal, aligned request, the block SHALL register the address, byte enables, write data, direction and op, then go to REQ.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-024 IDLE: on req_valid with an illegal or misaligned request, the block SHALL go to ERR and issue no bus cycle.
REQ-025 REQ: bus_valid SHALL be 1 and all bus outputs SHALL be held stable until bus_ready=1.
REQ-026 REQ with bus_ready=1:
  - store: go to DONE;
  - load with bus_rvalid=1 in the same cycle: capture the data and go to DONE;
  - otherwise: go to RESP.
REQ-027 RESP: bus_valid SHALL be 0; on bus_rvalid=1 the block SHALL capture bus_rdata and go to DONE.
REQ-028 DONE: stall SHALL be 0 and data_out SHALL hold the formatted load data; the next state SHALL be IDLE.
REQ-029 ERR: stall SHALL be 0 and err SHALL be 1 for exactly one cycle, then the state SHALL go to IDLE; data_out SHALL be 0.
REQ-030 stall = req_valid AND state in {IDLE, REQ, RESP}.
  - This gives at least 2 stall cycles per access when the bus is zero-wait: IDLE, REQ, then release in DONE.
REQ-031 Byte enables:
  - SB: 4'b0001 shifted left by addr[1:0];
  - SH: 4'b0011 shifted left by 2*addr[1];
  - SW: 4'b1111;
  - loads use the same lane pattern as the matching width.
REQ-032 bus_wdata:
  - SB: {4{data_in[7:0]}};
  - SH: {2{data_in[15:0]}};
  - SW: data_in.
REQ-033 Load formatting: select the byte or halfword by addr[1:0]; LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through.
REQ-034 A timeout counter SHALL clear on entry to REQ and increment every cycle in REQ or RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 with no completing event that cycle, the state SHALL go to ERR.
  - A completing event in that same cycle wins over the timeout.
REQ-035 A bus_rvalid arriving in IDLE, DONE or ERR SHALL be ignored.
REQ-036 A change of req_valid while in REQ or RESP SHALL NOT abort the bus transaction.

Reset
REQ-037 While reset=1, the block SHALL immediately and asynchronously force: state=IDLE, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, data_out=0, err=0, timeout counter=0.
REQ-038 A reset asserted in REQ or RESP SHALL drop bus_valid in the same cycle, and any later bus_rvalid SHALL be discarded.
REQ-039 With reset=1, stall SHALL be 0.

Verification
REQ-040 Scenario: SW addr=0x100, data_in=0xDEADBEEF, bus_ready tied to 1 -> bus_we=1, bus_be=1111, bus_addr=0x100, bus_wdata=0xDEADBEEF; stall high 2 cycles, then DONE.
REQ-041 Scenario: LB addr=0x103, bus_rdata=0x80FF_0000, rvalid 2 cycles after ready -> bus_be=1000, data_out=0xFFFFFF80; LBU on the same data gives 0x00000080.
REQ-042 Scenario: LH addr=0x102 with the same data -> data_out=0xFFFF80FF; SH addr=0x102, data_in=0x1234 -> bus_be=1100, bus_wdata=0x12341234.
REQ-043 Scenario: LW addr=0x101, or load_ops=011 -> no bus_valid, err pulses 1 cycle, stall releases.
REQ-044 Scenario: bus_ready held 0 for 16 cycles (TIMEOUT_CYCLES=16) -> ERR reached, err=1, bus_valid drops; with bus_ready=1 on the 16th REQ cycle -> normal completion, no err.
REQ-045 Scenario: reset pulsed while in RESP -> bus_valid=0 and data_out=0 immediately; a bus_rvalid 1 cycle later is ignored and the next SW proceeds normally.
